// File: rtl/rca_arbiter.sv
// Round-robin arbiter that sequences a 32-bit add as two 16-bit passes through the shared
// ripple-carry adder (low half, then high half) and returns one tagged 33-bit result.
module rca_arbiter #(
    parameter int unsigned ADD_LAT = 2
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        REQ0_VALID,
    output logic        REQ0_READY,
    input  logic [31:0] REQ0_A,
    input  logic [31:0] REQ0_B,
    input  logic        REQ0_CIN,
    input  logic        REQ1_VALID,
    output logic        REQ1_READY,
    input  logic [31:0] REQ1_A,
    input  logic [31:0] REQ1_B,
    input  logic        REQ1_CIN,
    output logic        RSP_VALID,
    input  logic        RSP_READY,
    output logic        RSP_ID,
    output logic [31:0] RSP_SUM,
    output logic        RSP_COUT,
    output logic [31:0] ADD_A,
    output logic [31:0] ADD_B,
    output logic        ADD_C_IN,
    output logic        ADD_FLAG,
    input  logic [15:0] ADD_S,
    input  logic        ADD_C_OUT
);

    typedef enum logic [1:0] {StIdle, StLo, StHi, StResp} state_e;

    // Each pass holds the adder inputs for ADD_LAT+1 cycles; the last one is cnt == LastCnt.
    localparam logic [2:0] LastCnt = 3'(ADD_LAT);

    state_e      state_q, state_d;
    logic        ptr_q, ptr_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        id_q, id_d;
    logic [15:0] sum_lo_q, sum_lo_d;
    logic [31:0] add_a_q, add_a_d;
    logic [31:0] add_b_q, add_b_d;
    logic        add_c_in_q, add_c_in_d;
    logic        add_flag_q, add_flag_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic        rsp_id_q, rsp_id_d;
    logic [31:0] rsp_sum_q, rsp_sum_d;
    logic        rsp_cout_q, rsp_cout_d;

    logic grant0, grant1, idle_ok;

    // ptr only breaks ties; a lone requester is always granted.
    assign grant0  = REQ0_VALID & (~REQ1_VALID | ~ptr_q);
    assign grant1  = REQ1_VALID & (~REQ0_VALID | ptr_q);
    assign idle_ok = (state_q == StIdle) & RST_N;

    assign REQ0_READY = idle_ok & grant0;
    assign REQ1_READY = idle_ok & grant1;

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        cnt_d       = cnt_q;
        id_d        = id_q;
        sum_lo_d    = sum_lo_q;
        add_a_d     = add_a_q;
        add_b_d     = add_b_q;
        add_c_in_d  = add_c_in_q;
        add_flag_d  = add_flag_q;
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        rsp_sum_d   = rsp_sum_q;
        rsp_cout_d  = rsp_cout_q;

        case (state_q)
            StIdle: begin
                if (REQ0_READY || REQ1_READY) begin
                    id_d       = REQ1_READY;
                    add_a_d    = REQ1_READY ? REQ1_A : REQ0_A;
                    add_b_d    = REQ1_READY ? REQ1_B : REQ0_B;
                    add_c_in_d = REQ1_READY ? REQ1_CIN : REQ0_CIN;
                    add_flag_d = 1'b0;
                    ptr_d      = REQ0_READY;
                    cnt_d      = 3'd0;
                    state_d    = StLo;
                end
            end
            StLo: begin
                if (cnt_q == LastCnt) begin
                    sum_lo_d   = ADD_S;
                    add_flag_d = 1'b1;
                    cnt_d      = 3'd0;
                    state_d    = StHi;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            StHi: begin
                // Same operands in both passes, so the upper half already has the bit-15 carry.
                if (cnt_q == LastCnt) begin
                    rsp_sum_d   = {ADD_S, sum_lo_q};
                    rsp_cout_d  = ADD_C_OUT;
                    rsp_id_d    = id_q;
                    rsp_valid_d = 1'b1;
                    cnt_d       = 3'd0;
                    state_d     = StResp;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            StResp: begin
                if (RSP_READY) begin
                    rsp_valid_d = 1'b0;
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q     <= StIdle;
            ptr_q       <= 1'b0;
            cnt_q       <= 3'd0;
            id_q        <= 1'b0;
            sum_lo_q    <= 16'd0;
            add_a_q     <= 32'd0;
            add_b_q     <= 32'd0;
            add_c_in_q  <= 1'b0;
            add_flag_q  <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= 1'b0;
            rsp_sum_q   <= 32'd0;
            rsp_cout_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            cnt_q       <= cnt_d;
            id_q        <= id_d;
            sum_lo_q    <= sum_lo_d;
            add_a_q     <= add_a_d;
            add_b_q     <= add_b_d;
            add_c_in_q  <= add_c_in_d;
            add_flag_q  <= add_flag_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_sum_q   <= rsp_sum_d;
            rsp_cout_q  <= rsp_cout_d;
        end
    end

    assign ADD_A     = add_a_q;
    assign ADD_B     = add_b_q;
    assign ADD_C_IN  = add_c_in_q;
    assign ADD_FLAG  = add_flag_q;
    assign RSP_VALID = rsp_valid_q;
    assign RSP_ID    = rsp_id_q;
    assign RSP_SUM   = rsp_sum_q;
    assign RSP_COUT  = rsp_cout_q;

endmodule

// File: doc/rca_arbiter.md
# rca_arbiter

Two-requester arbiter and sequencer for the shared 32-bit ripple-carry adder datapath. The adder's sum port is 16 bits wide. A `FLAG` input selects which half of the sum it presents. This block accepts 32-bit add requests from two clients and grants them round-robin. It runs the adder twice per request: low half, then high half. It returns one 32-bit sum plus carry-out on a single tagged response channel. It sits between the client logic and the registered adder wrapper.

## Interface
- `ADD_LAT`, default 2: cycles from `ADD_*` inputs first driven to valid `ADD_S`/`ADD_C_OUT`. Legal range 1..7.
- `CLK` in 1: single clock, rising edge.
- `RST_N` in 1: asynchronous, active-low reset.
- `REQ0_VALID` / `REQ1_VALID` in 1 each: request valid.
- `REQ0_READY` / `REQ1_READY` out 1 each: request accepted when VALID&READY.
- `REQ0_A`, `REQ0_B` / `REQ1_A`, `REQ1_B` in 32 each: operands.
- `REQ0_CIN` / `REQ1_CIN` in 1 each: carry-in.
- `RSP_VALID` out 1: response valid.
- `RSP_READY` in 1: response consumed when VALID&READY.
- `RSP_ID` out 1: index of the requester that issued the op.
- `RSP_SUM` out 32: A+B+CIN mod 2^32.
- `RSP_COUT` out 1: carry out of bit 31.
- `ADD_A`, `ADD_B` out 32: adder operands. Registered.
- `ADD_C_IN` out 1: adder carry-in. Registered.
- `ADD_FLAG` out 1: 0 selects sum[15:0], 1 selects sum[31:16]. Registered.
- `ADD_S` in 16: adder sum half selected by `ADD_FLAG`.
- `ADD_C_OUT` in 1: adder carry out of bit 31. Valid for either `FLAG` value.

## Operation
- FSM states: IDLE, LO, HI, RESP.
- **IDLE**
  - `REQx_READY` = 1 only for the requester chosen by the arbiter.
  - If only one requester is valid, it is chosen.
  - If both are valid, the one selected by the priority pointer `ptr` is chosen.
  - `REQx_READY` is combinational from `REQx_VALID` and `ptr`. At most one READY is high.
  - On accept:
    - Capture A, B, CIN and ID.
    - Load `ADD_A`/`ADD_B`/`ADD_C_IN` with the captured values and set `ADD_FLAG`=0.
    - Set `ptr` to the non-granted index.
    - Go to LO.
- **LO**
  - Hold all `ADD_*` outputs for ADD_LAT+1 cycles.
  - On the last cycle, capture `ADD_S` into `sum[15:0]`.
  - Set `ADD_FLAG`=1 and go to HI.
- **HI**
  - Hold for ADD_LAT+1 cycles.
  - On the last cycle, capture `ADD_S` into `sum[31:16]` and `ADD_C_OUT` into cout.
  - Go to RESP.
- **RESP**
  - `RSP_VALID`=1 with `RSP_ID`/`RSP_SUM`/`RSP_COUT` stable.
  - Stay in RESP until `RSP_READY`, then go to IDLE.
- Both passes feed the adder identical A, B and C_IN; only `FLAG` differs. The high half therefore already includes the carry from bit 15.
- Wrap-around: a 32-bit overflow is reported only through `RSP_COUT`. `RSP_SUM` is the truncated value.
- Requester protocol: once raised, VALID and operands are held until READY. The block does not check this.
- `REQx_READY` is 0 in LO, HI and RESP. No requests are queued.
- **Reset**, asynchronous (also mid-operation):
  - state=IDLE, `ptr`=0, cycle counter=0.
  - `ADD_A`=`ADD_B`=0, `ADD_C_IN`=0, `ADD_FLAG`=0.
  - `RSP_VALID`=0, `RSP_ID`=0, `RSP_SUM`=0, `RSP_COUT`=0.
  - `REQx_READY`=0 while `RST_N`=0.
  - Any in-flight op is discarded and produces no response.

## Timing
- All outputs except `REQx_READY` are registered.
- Accept edge ends cycle T:
  - LO occupies cycles T+1 .. T+1+ADD_LAT.
  - HI occupies cycles T+2+ADD_LAT .. T+2+2·ADD_LAT.
  - `RSP_VALID` rises in cycle T+3+2·ADD_LAT. For ADD_LAT=2 that is T+7.
- `ADD_FLAG` rises in cycle T+2+ADD_LAT and returns to 0 on the next accept.
- Between ops, `ADD_*` hold their last values.
- With `RSP_READY` held high, the next accept can occur no earlier than 2·ADD_LAT+4 cycles after the previous one (8 cycles for ADD_LAT=2).
- Back-pressure: each cycle of `RSP_READY`=0 in RESP delays the return to IDLE by one cycle. Response fields do not change during the stall.

## Test plan
Bench adder model: registered, ADD_LAT=2, correct `FLAG` half-select.
- **Single op.** REQ0 A=0x12345678, B=0x11111111, CIN=0. Response: `RSP_SUM`=0x23456789, `RSP_COUT`=0, `RSP_ID`=0, `RSP_VALID` 7 cycles after accept.
- **Half-boundary carry.** REQ1 A=0x0000FFFF, B=0x00000001, CIN=0. Response: `RSP_SUM`=0x00010000, `RSP_COUT`=0, `RSP_ID`=1. `ADD_FLAG` seen 0 for 3 cycles, then 1 for 3 cycles.
- **Overflow.** REQ0 A=0xFFFFFFFF, B=0, CIN=1. Response: `RSP_SUM`=0x00000000, `RSP_COUT`=1.
- **Fairness.** Both VALID continuously from reset for 4 ops. Grants in order 0,1,0,1. `RSP_ID` sequence 0,1,0,1. Accepts spaced exactly 8 cycles apart.
- **Back-pressure.** Hold `RSP_READY`=0 for 5 cycles after `RSP_VALID`. Response fields stay constant. Both `REQx_READY` stay 0. The next accept occurs one cycle after the `RSP_READY` handshake.
- **Reset mid-op.** Drop `RST_N` during HI. All outputs go immediately to their reset values. After release, no response appears for the aborted op. A new REQ1 op completes correctly and is granted first over a simultaneous REQ0 only if `ptr` favours it (`ptr`=0 ⇒ REQ0 first).
